// File: rtl/fixed_point_complex_accumulator_pkg.sv
// Shared types and helpers for the complex accumulator: FSM state encoding,
// counter sizing and the default-width saturation limits.
package fpcacc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    // A single-term block still needs a 1-bit counter.
    function automatic int cnt_width(input int terms);
        return (terms <= 1) ? 1 : $clog2(terms);
    endfunction

endpackage

// File: rtl/fixed_point_complex_accumulator_if.sv
// Product-in / sum-out handshake bundle between multiplier, accumulator and consumer.
interface fpcacc_if #(
    parameter int DATA_W = 32
);
    logic                     recv_val;
    logic                     recv_rdy;
    logic signed [DATA_W-1:0] pr;
    logic signed [DATA_W-1:0] pc;
    logic                     send_val;
    logic                     send_rdy;
    logic signed [DATA_W-1:0] sr;
    logic signed [DATA_W-1:0] sc;
    logic                     ovf;

    modport master (
        output recv_val, pr, pc, send_rdy,
        input  recv_rdy, send_val, sr, sc, ovf
    );

    modport slave (
        input  recv_val, pr, pc, send_rdy,
        output recv_rdy, send_val, sr, sc, ovf
    );
endinterface

// File: rtl/fixed_point_complex_accumulator_sat_adder.sv
// Combinational signed adder with overflow flag and optional clamp to the
// representable range.
module sat_adder #(
    parameter int DATA_W = 32,
    parameter bit SAT    = 1'b1
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] sum,
    output logic                     ovf
);
    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    // Overflow direction follows the shared operand sign.
    function automatic logic signed [DATA_W-1:0] clamp(
        input logic signed [DATA_W-1:0] raw_v,
        input logic                     neg,
        input logic                     hit
    );
        if (SAT && hit) return neg ? MIN_V : MAX_V;
        return raw_v;
    endfunction

    logic signed [DATA_W-1:0] raw;

    assign raw = a + b;
    assign ovf = (a[DATA_W-1] == b[DATA_W-1]) && (raw[DATA_W-1] != a[DATA_W-1]);
    assign sum = clamp(raw, a[DATA_W-1], ovf);

endmodule

// File: rtl/fixed_point_complex_accumulator.sv
// Sums NUM_TERMS complex products per block and hands the result downstream,
// holding it until accepted before clearing for the next block.
module fixed_point_complex_accumulator
    import fpcacc_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_W    = 16,
    parameter int NUM_TERMS = 8,
    parameter bit SAT       = 1'b1
) (
    input  logic    clk,
    input  logic    reset,
    fpcacc_if.slave bus
);
    if (NUM_TERMS < 1 || FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_params
        $error("fixed_point_complex_accumulator: invalid NUM_TERMS/FRAC_W");
    end

    localparam int             CNT_W = cnt_width(NUM_TERMS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q;
    logic signed [DATA_W-1:0] acc_r, acc_c;
    logic signed [DATA_W-1:0] sum_r, sum_c;
    logic                     ovf_r, ovf_c, ovf_q;
    logic                     recv_rdy, send_val, acc_en, clr;

    sat_adder #(.DATA_W(DATA_W), .SAT(SAT)) u_add_r (
        .a(acc_r), .b(bus.pr), .sum(sum_r), .ovf(ovf_r)
    );

    sat_adder #(.DATA_W(DATA_W), .SAT(SAT)) u_add_c (
        .a(acc_c), .b(bus.pc), .sum(sum_c), .ovf(ovf_c)
    );

    always_comb begin
        state_d  = state_q;
        recv_rdy = 1'b0;
        send_val = 1'b0;
        acc_en   = 1'b0;
        clr      = 1'b0;
        case (state_q)
            ACC: begin
                recv_rdy = 1'b1;
                if (bus.recv_val) begin
                    acc_en = 1'b1;
                    if (count_q == LAST) state_d = DONE;
                end
            end
            DONE: begin
                send_val = 1'b1;
                if (bus.send_rdy) begin
                    clr     = 1'b1;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // Registered sums feed the outputs directly; reset drops any partial block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACC;
            count_q <= '0;
            acc_r   <= '0;
            acc_c   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc_en) begin
                acc_r   <= sum_r;
                acc_c   <= sum_c;
                ovf_q   <= ovf_q | ovf_r | ovf_c;
                count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
            end else if (clr) begin
                acc_r <= '0;
                acc_c <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.recv_rdy = recv_rdy;
    assign bus.send_val = send_val;
    assign bus.sr       = acc_r;
    assign bus.sc       = acc_c;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_fixed_point_complex_accumulator.sv
// Directed bench for the complex accumulator: block-sum table plus
// backpressure and asynchronous-reset sequences across three configurations.
module tb_fixed_point_complex_accumulator;
    import fpcacc_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    // a: 4 terms saturating, b: 2 terms saturating, c: 2 terms wrapping
    fpcacc_if #(.DATA_W(32)) if_a ();
    fpcacc_if #(.DATA_W(32)) if_b ();
    fpcacc_if #(.DATA_W(32)) if_c ();

    fixed_point_complex_accumulator #(.DATA_W(32), .FRAC_W(16), .NUM_TERMS(4), .SAT(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave)
    );
    fixed_point_complex_accumulator #(.DATA_W(32), .FRAC_W(16), .NUM_TERMS(2), .SAT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave)
    );
    fixed_point_complex_accumulator #(.DATA_W(32), .FRAC_W(16), .NUM_TERMS(2), .SAT(1'b0)) dut_c (
        .clk(clk), .reset(reset), .bus(if_c.slave)
    );

    typedef struct {
        logic        recv_rdy;
        logic        send_val;
        logic [31:0] sr;
        logic [31:0] sc;
        logic        ovf;
    } obs_t;

    typedef struct {
        int              sel;
        int              nterms;
        logic [3:0][31:0] pr;
        logic [3:0][31:0] pc;
        logic [31:0]     exp_sr;
        logic [31:0]     exp_sc;
        logic            exp_ovf;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [31:0] r, input logic [31:0] c);
        case (sel)
            0: begin if_a.recv_val = v; if_a.pr = r; if_a.pc = c; end
            1: begin if_b.recv_val = v; if_b.pr = r; if_b.pc = c; end
            default: begin if_c.recv_val = v; if_c.pr = r; if_c.pc = c; end
        endcase
    endtask

    task automatic set_srdy(input int sel, input logic v);
        case (sel)
            0: if_a.send_rdy = v;
            1: if_b.send_rdy = v;
            default: if_c.send_rdy = v;
        endcase
    endtask

    function automatic obs_t obs(input int sel);
        obs_t o;
        case (sel)
            0: o = '{if_a.recv_rdy, if_a.send_val, if_a.sr, if_a.sc, if_a.ovf};
            1: o = '{if_b.recv_rdy, if_b.send_val, if_b.sr, if_b.sc, if_b.ovf};
            default: o = '{if_c.recv_rdy, if_c.send_val, if_c.sr, if_c.sc, if_c.ovf};
        endcase
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted product: recv_rdy must be high going into the edge.
    task automatic feed(input int sel, input logic [31:0] r, input logic [31:0] c, input string name);
        obs_t o;
        drive(sel, 1'b1, r, c);
        o = obs(sel);
        check({name, " recv_rdy before accept"}, o.recv_rdy, 1);
        step();
        drive(sel, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic vec_t mk(input int sel, input int nterms,
                                input logic [3:0][31:0] pr, input logic [3:0][31:0] pc,
                                input logic [31:0] esr, input logic [31:0] esc, input logic eovf);
        vec_t v;
        v.sel = sel; v.nterms = nterms; v.pr = pr; v.pc = pc;
        v.exp_sr = esr; v.exp_sc = esc; v.exp_ovf = eovf;
        return v;
    endfunction

    vec_t vecs[8];
    obs_t o;

    initial begin
        vecs[0] = mk(0, 4, {4{32'h0001_0000}}, {4{32'h0000_8000}}, 32'h0004_0000, 32'h0002_0000, 1'b0);
        vecs[1] = mk(0, 4, {32'hFFFF_C000, 32'h0000_4000, 32'hFFFD_0000, 32'h0002_0000},
                     {4{32'h0}}, 32'hFFFF_0000, 32'h0, 1'b0);
        vecs[2] = mk(1, 2, {4{32'h7FFF_0000}}, {4{32'h0}}, 32'h7FFF_FFFF, 32'h0, 1'b1);
        vecs[3] = mk(1, 2, {32'h0, 32'h0, 32'h20, 32'h10}, {4{32'hFFFF_FFFF}}, 32'h30, 32'hFFFF_FFFE, 1'b0);
        vecs[4] = mk(2, 2, {4{32'h7FFF_0000}}, {4{32'h0}}, 32'hFFFE_0000, 32'h0, 1'b1);
        vecs[5] = mk(1, 2, {4{32'h8000_0000}}, {4{32'h0}}, 32'h8000_0000, 32'h0, 1'b1);
        vecs[6] = mk(2, 2, {4{32'h8000_0000}}, {4{32'h0}}, 32'h0000_0000, 32'h0, 1'b1);
        vecs[7] = mk(2, 2, {32'h0, 32'h0, 32'h2, 32'h1}, {4{32'h4000_0000}}, 32'h3, 32'h8000_0000, 1'b1);

        for (int s = 0; s < 3; s++) begin
            drive(s, 1'b0, 32'h0, 32'h0);
            set_srdy(s, 1'b0);
        end
        #12;
        o = obs(0);
        check("reset recv_rdy", o.recv_rdy, 1);
        check("reset send_val", o.send_val, 0);
        check("reset sr", o.sr, 32'h0);
        check("reset sc", o.sc, 32'h0);
        check("reset ovf", o.ovf, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Block sums, send_rdy held high
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            set_srdy(vecs[i].sel, 1'b1);
            for (int k = 0; k < vecs[i].nterms; k++)
                feed(vecs[i].sel, vecs[i].pr[k], vecs[i].pc[k], tag);
            o = obs(vecs[i].sel);
            check({tag, " send_val"}, o.send_val, 1);
            check({tag, " recv_rdy in DONE"}, o.recv_rdy, 0);
            check({tag, " sr"}, o.sr, vecs[i].exp_sr);
            check({tag, " sc"}, o.sc, vecs[i].exp_sc);
            check({tag, " ovf"}, o.ovf, vecs[i].exp_ovf);
            step();
            o = obs(vecs[i].sel);
            check({tag, " recv_rdy after send"}, o.recv_rdy, 1);
            check({tag, " send_val after send"}, o.send_val, 0);
        end

        // Backpressure: result held, extra product waits for the send handshake
        set_srdy(0, 1'b0);
        for (int k = 0; k < 4; k++) feed(0, 32'h0001_0000, 32'h0, "bp fill");
        drive(0, 1'b1, 32'h0001_0000, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            o = obs(0);
            check("bp send_val held", o.send_val, 1);
            check("bp recv_rdy low", o.recv_rdy, 0);
            check("bp sr stable", o.sr, 32'h0004_0000);
            check("bp sc stable", o.sc, 32'h0);
        end
        set_srdy(0, 1'b1);
        step();
        set_srdy(0, 1'b0);
        o = obs(0);
        check("bp send_val dropped", o.send_val, 0);
        check("bp recv_rdy back", o.recv_rdy, 1);
        check("bp sr cleared", o.sr, 32'h0);
        step();
        drive(0, 1'b0, 32'h0, 32'h0);
        o = obs(0);
        check("bp extra absorbed once", o.sr, 32'h0001_0000);
        set_srdy(0, 1'b1);
        for (int k = 0; k < 3; k++) feed(0, 32'h0001_0000, 32'h0, "bp rest");
        o = obs(0);
        check("bp block send_val", o.send_val, 1);
        check("bp block sr", o.sr, 32'h0004_0000);
        step();

        // Asynchronous reset in the middle of a block
        feed(0, 32'h0001_0000, 32'h0001_0000, "ar pre");
        feed(0, 32'h0001_0000, 32'h0001_0000, "ar pre");
        o = obs(0);
        check("ar partial sr", o.sr, 32'h0002_0000);
        #3;
        reset = 1'b0;
        #1;
        o = obs(0);
        check("ar sr cleared async", o.sr, 32'h0);
        check("ar sc cleared async", o.sc, 32'h0);
        check("ar recv_rdy", o.recv_rdy, 1);
        check("ar send_val", o.send_val, 0);
        @(posedge clk);
        #4;
        reset = 1'b1;
        step();
        for (int k = 0; k < 3; k++) feed(0, 32'h0001_0000, 32'h0, "ar post");
        o = obs(0);
        check("ar no early send_val", o.send_val, 0);
        feed(0, 32'h0001_0000, 32'h0, "ar post");
        o = obs(0);
        check("ar post send_val", o.send_val, 1);
        check("ar post sr", o.sr, 32'h0004_0000);
        check("ar post sc", o.sc, 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_point_complex_accumulator.md
Name: fixed_point_complex_accumulator

Overview:
- Downstream consumer of the fixed-point iterative complex multiplier.
- Takes a stream of complex products (real, imaginary) over a val/rdy handshake and sums exactly m of them into a running complex sum.
- After the m-th term, presents the sum on a val/rdy output, then clears itself for the next block.
- Forms the accumulate half of a complex dot-product / correlator (multiplier then accumulator).

Parameters:
- n, 32, bit width of every data word (signed two's complement fixed point).
- d, 16, number of fractional bits. Carried for format consistency only; addition is format-agnostic.
- m, 8, number of products summed per result (m >= 1).
- sat, 1, 1 = saturating add, 0 = wrap-around add.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting low clears all state immediately, independent of clk.
- recv_val  input  1  upstream product valid.
- recv_rdy  output  1  accumulator can accept a product.
- pr  input  n  product real part.
- pc  input  n  product imaginary part.
- send_val  output  1  sum valid.
- send_rdy  input  1  downstream accepts sum.
- sr  output  n  accumulated real sum.
- sc  output  n  accumulated imaginary sum.
- ovf  output  1  sticky: at least one add in this block saturated (sat=1) or wrapped (sat=0).

Behaviour:
- Reset (reset low, async) sets:
  - state=ACC, count=0, acc_r=0, acc_c=0, ovf=0;
  - recv_rdy=1, send_val=0, sr=sc=0.
- Reset mid-block discards the partial sum; no output is produced for it.
- sr/sc/ovf are driven directly from registers, with no combinational path from inputs.
- State ACC:
  - recv_rdy=1, send_val=0.
  - On recv_val&recv_rdy: acc_r<=add(acc_r,pr), acc_c<=add(acc_c,pc).
  - ovf<=ovf | overflow_r | overflow_c.
  - If count==m-1: count<=0 and state<=DONE. Otherwise count<=count+1.
- State DONE:
  - recv_rdy=0, send_val=1; sr/sc/ovf hold stable while send_rdy=0.
  - On send_rdy: acc_r<=0, acc_c<=0, ovf<=0, state<=ACC.
  - recv_rdy rises the following cycle; no same-cycle bypass.
- Latency and throughput:
  - send_val asserts the cycle after the m-th handshake.
  - Minimum period is m+1 cycles per result when send_rdy is held high.
- recv_val while recv_rdy=0 has no effect; upstream holds its data.
- pr/pc are don't-care when recv_val=0.
- add() is signed n-bit:
  - Overflow is detected when both operands share a sign and the result sign differs.
  - sat=1: positive overflow clamps to 2^(n-1)-1, negative overflow clamps to -2^(n-1).
  - sat=0: result is the low n bits (wrap); ovf is still flagged.
- m=1: every accepted product goes straight to DONE.
- count width is clog2(m) with a minimum of 1 bit. count never exceeds m-1.

Decomposition:
- Shared package fpcacc_pkg holds:
  - state enum {ACC, DONE};
  - function for count width (clog2 with min 1);
  - localparams SAT_MAX/SAT_MIN derived from n.
- One sub-module: sat_adder (parameters n, sat; inputs a, b; outputs sum, ovf). It is purely combinational and instantiated twice (real, imaginary).
- Top level holds the FSM, counter, and registers.

Test Plan:
- Reset, then m=4, feed 1.0+0.5j (pr=0x00010000, pc=0x00008000) four times back-to-back with send_rdy=1:
  - send_val asserts one cycle after the 4th accept with sr=0x00040000, sc=0x00020000, ovf=0;
  - recv_rdy returns next cycle.
- Mixed signs, m=4, inputs 2.0, -3.0, 0.25, -0.25 (real) and 0 (imag) → sr=0xFFFF0000 (-1.0), sc=0.
- Backpressure: hold send_rdy=0 for 5 cycles after DONE:
  - sr/sc stay constant and recv_rdy stays 0 while recv_val=1;
  - the extra product is not absorbed and is accepted only after send_rdy pulses.
- Saturation, sat=1, m=2, pr=0x7FFF0000 twice → sr=0x7FFFFFFF, ovf=1. Next block with small values → ovf=0 again.
- Wrap, sat=0, same stimulus → sr=0xFFFE0000, ovf=1. Negative case pr=0x80000000 twice with sat=1 → sr=0x80000000, ovf=1.
- Async reset: drive reset low mid-block (after 2 of 4 accepts) between clock edges:
  - outputs clear immediately;
  - after release, 4 new inputs of 1.0 give sr=0x00040000, with no residue from the aborted block.
